// File: rtl/vga_sync_gen.sv
// vga_sync_gen
//   VGA timing generator (640x480@60 by default). Runs on the system clock.
//   The pixel tick is used as a clock-enable only, never as a clock.
//   Horizontal and vertical counters advance on pix_en. hsync, vsync,
//   video_on and frame_start are registered from the next-state counter
//   values, so they line up with x/y in the same cycle.
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-high reset
//   pix_en       pixel tick; state advances only on clk edges with pix_en=1
//   hsync/vsync  sync pulses, polarity set by SYNC_ACTIVE_LOW
//   video_on     high inside the visible area
//   x, y         current horizontal / vertical count
//   frame_start  one-clk pulse when the counters wrap to (0,0)
//   frame_cnt    8-bit frame counter (only with VGA_FRAME_COUNT_EN defined)
//
// Optional feature macro: VGA_FRAME_COUNT_EN
module vga_sync_gen #(
  parameter int H_ACTIVE        = 640,
  parameter int H_FP            = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BP            = 48,
  parameter int V_ACTIVE        = 480,
  parameter int V_FP            = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BP            = 33,
  parameter int SYNC_ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_en,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       frame_start
`ifdef VGA_FRAME_COUNT_EN
  ,
  output logic [7:0] frame_cnt
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic       SYNC_INV = (SYNC_ACTIVE_LOW != 0);

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic [9:0] h_nxt;
  logic [9:0] v_nxt;
  logic       frame_wrap;

  // Pin level for a sync interval flag (inverted for active-low sync).
  function automatic logic sync_level(input logic active);
    return active ^ SYNC_INV;
  endfunction

  function automatic logic in_window(input logic [9:0] cnt,
                                     input logic [9:0] lo,
                                     input logic [9:0] hi);
    return (cnt >= lo) && (cnt < hi);
  endfunction

  // Next-state counters; wrap by compare so non-power-of-two totals work.
  always_comb begin
    h_nxt      = h_cnt;
    v_nxt      = v_cnt;
    frame_wrap = 1'b0;
    if (pix_en) begin
      if (h_cnt == H_LAST) begin
        h_nxt = '0;
        if (v_cnt == V_LAST) begin
          v_nxt      = '0;
          frame_wrap = 1'b1;
        end else begin
          v_nxt = v_cnt + 10'd1;
        end
      end else begin
        h_nxt = h_cnt + 10'd1;
      end
    end
  end

  // Counters and decoded outputs registered together, decoded from the
  // next-state values so every output matches x/y in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      hsync       <= sync_level(1'b0);
      vsync       <= sync_level(1'b0);
      video_on    <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      h_cnt       <= h_nxt;
      v_cnt       <= v_nxt;
      hsync       <= sync_level(in_window(h_nxt, HS_BEG, HS_END));
      vsync       <= sync_level(in_window(v_nxt, VS_BEG, VS_END));
      video_on    <= (h_nxt < H_VIS) && (v_nxt < V_VIS);
      frame_start <= frame_wrap;
    end
  end

  assign x = h_cnt;
  assign y = v_cnt;

`ifdef VGA_FRAME_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt <= '0;
    end else if (frame_wrap) begin
      frame_cnt <= frame_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Consumes the pixel-rate tick from the clock divider and generates VGA 640x480@60 timing.
- Produces the hsync and vsync pins, the active-video flag and the current pixel coordinates for the pixel/colour logic downstream.
- Runs entirely on the system clock. The divider output is used as a clock-enable, never as a clock.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_ACTIVE_LOW, 1, 1 = hsync/vsync low during the sync interval, 0 = high

Ports:
- clk  in  1  system clock (100 MHz)
- reset  in  1  asynchronous, active-high reset
- pix_en  in  1  pixel tick (divided_clk from clock_divider, or a 1-cycle strobe); counters advance only on clk edges where pix_en=1
- hsync  out  1  horizontal sync, polarity set by SYNC_ACTIVE_LOW
- vsync  out  1  vertical sync, polarity set by SYNC_ACTIVE_LOW
- video_on  out  1  high while h_cnt<H_ACTIVE and v_cnt<V_ACTIVE
- x  out  10  current horizontal count 0..H_TOTAL-1
- y  out  10  current vertical count 0..V_TOTAL-1
- frame_start  out  1  one-clk pulse on the pix_en edge where counters wrap to (0,0)

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP = 525.
- Reset (asynchronous, immediate):
  - h_cnt = 0, v_cnt = 0, x = 0, y = 0
  - video_on = 1
  - hsync and vsync deasserted (1 when SYNC_ACTIVE_LOW=1)
  - frame_start = 0
- Reset mid-frame: counters return to (0,0) immediately with no partial-line completion. The first pix_en after reset release moves to (1,0).
- Horizontal counter, on clk edge with pix_en=1:
  - h_cnt == H_TOTAL-1 → h_cnt = 0, and the line-end step fires
  - otherwise h_cnt increments by 1
- Vertical counter steps only on the line-end step:
  - v_cnt == V_TOTAL-1 → v_cnt = 0
  - otherwise v_cnt increments by 1
- Both counters are 10 bits. Wrap is by compare, never by natural overflow.
- Decode, all outputs registered and aligned with the counters (x = h_cnt, y = v_cnt in the same cycle):
  - hsync asserted while H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751
  - vsync asserted while V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, i.e. 490..491
  - video_on = (h_cnt<640) && (v_cnt<480)
- Outputs are computed from next-state counter values so there is zero latency between x/y and hsync/vsync/video_on.
- pix_en=0: all state holds. frame_start is driven 0 on every cycle where pix_en=0.
- frame_start = 1 for exactly one clk, on the edge where (h_cnt,v_cnt) goes from (799,524) to (0,0). It is not asserted at reset release.
- pix_en held continuously high is legal: the counters then advance every clk.
- Only reset and pix_en affect state. There is no other input-driven event, so no simultaneous-event priority is needed.

Optional Feature:
- Macro: VGA_FRAME_COUNT_EN
- Defined:
  - Adds output port frame_cnt (out, 8 bits).
  - Reset value 0.
  - Increments by 1 on every frame_start pulse; wraps 255 → 0.
  - Intended for blink/animation timing in the game display.
- Undefined: no frame_cnt port or register; all other behaviour is identical.

Test Plan:
- Reset asserted mid-line at (h=300, v=100), then released → outputs immediately x=0, y=0, hsync=vsync=1, video_on=1; first pix_en gives x=1.
- pix_en every 4th clk (divider-style) for 2 lines → x runs 0..799 and wraps with y 0→1→2; hsync low exactly for x=656..751 (96 pixel ticks); video_on=0 for x>=640.
- pix_en=0 held for 50 clks at x=639 → x, y and all outputs frozen; next pix_en gives x=640 and video_on=0.
- Run a full frame → vsync low only for y=490..491 (1600 pixel ticks); video_on=0 for y>=480; y wraps 524→0 with frame_start high for exactly 1 clk.
- Count pix_en between two frame_start pulses → exactly 420000 (800×525).
- With VGA_FRAME_COUNT_EN defined, run 257 frames → frame_cnt goes 0,1,...,255,0,1. Without the macro, the bench compiles with no frame_cnt port.
